// File: rtl/conv_3x3_layer_sched_if.sv
// ---------------------------------------------------------------------------
// conv_3x3_layer_sched_if
// Groups the weight and pixel streams around the conv layer scheduler.
//   w_src_valid/w_src_data/w_src_ready : weight word from the weight reader
//   p_src_valid/p_src_data/p_src_ready : pixel word from the pixel reader
//   valid_weight_out/weight_out        : registered weight word to conv core
//   valid_pxl_out/pxl_out              : registered pixel word to loop-data
// master : scheduler side (accepts sources, drives datapath outputs)
// slave  : environment side (drives sources, observes outputs)
// ---------------------------------------------------------------------------
interface conv_3x3_layer_sched_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  w_src_valid;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  w_src_ready;
  logic                  p_src_valid;
  logic [DATA_WIDTH-1:0] p_src_data;
  logic                  p_src_ready;
  logic                  valid_weight_out;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  valid_pxl_out;
  logic [DATA_WIDTH-1:0] pxl_out;

  modport master (
    input  w_src_valid, w_src_data, p_src_valid, p_src_data,
    output w_src_ready, p_src_ready,
    output valid_weight_out, weight_out, valid_pxl_out, pxl_out
  );

  modport slave (
    output w_src_valid, w_src_data, p_src_valid, p_src_data,
    input  w_src_ready, p_src_ready,
    input  valid_weight_out, weight_out, valid_pxl_out, pxl_out
  );
endinterface

// File: rtl/conv_3x3_layer_sched.sv
// ---------------------------------------------------------------------------
// conv_3x3_layer_sched
// Sequences one 3x3 conv layer: for every output channel it loads that
// channel's weights into the conv core, then streams that channel's input
// pixels into the loop-data path. Adder results are counted and the layer
// completes once every expected result has come back.
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   start            : one-cycle layer start request (honoured only in IDLE)
//   stall_in         : downstream backpressure, blocks pixel acceptance
//   bus              : weight/pixel source handshakes and datapath outputs
//   valid_result_in  : one channel-adder result per asserted cycle
//   busy, done       : layer in progress / one-cycle completion pulse
//   oc_idx           : current output-channel pass
//   err              : sticky unexpected-result flag
// ---------------------------------------------------------------------------
module conv_3x3_layer_sched #(
  parameter int  DATA_WIDTH      = 32,
  parameter int  KERNEL          = 3,
  parameter int  CHANNEL_NUM_IN  = 128,
  parameter int  CHANNEL_NUM_OUT = 128,
  parameter int  IMAGE_SIZE      = 1024,
  localparam int OC_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stall_in,
  conv_3x3_layer_sched_if.master        bus,
  input  logic                          valid_result_in,
  output logic                          busy,
  output logic                          done,
  output logic [OC_W-1:0]               oc_idx,
  output logic                          err
);
  localparam int W_TERM = KERNEL * KERNEL * CHANNEL_NUM_IN;
  localparam int P_TERM = IMAGE_SIZE * CHANNEL_NUM_IN;
  localparam int R_TERM = IMAGE_SIZE * CHANNEL_NUM_OUT;
  localparam int W_CW   = $clog2(W_TERM + 1);
  localparam int P_CW   = $clog2(P_TERM + 1);
  localparam int R_CW   = $clog2(R_TERM + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [W_CW-1:0]       w_cnt_r;
  logic [P_CW-1:0]       p_cnt_r;
  logic [R_CW-1:0]       r_cnt_r;
  logic                  valid_weight_r, valid_pxl_r;
  logic [DATA_WIDTH-1:0] weight_r, pxl_r;

  logic w_rdy_s, p_rdy_s, w_hs_s, p_hs_s, w_last_s, p_last_s, oc_last_s;
  logic r_active_s, r_full_s, r_inc_s, r_bad_s, drain_done_s;

  assign bus.w_src_ready      = w_rdy_s;
  assign bus.p_src_ready      = p_rdy_s;
  assign bus.valid_weight_out = valid_weight_r;
  assign bus.weight_out       = weight_r;
  assign bus.valid_pxl_out    = valid_pxl_r;
  assign bus.pxl_out          = pxl_r;

  // Handshake qualification and result-count bookkeeping
  always_comb begin
    w_rdy_s    = (state_r == S_LOAD_W);
    // stall_in gates ready in the same cycle since there is no skid buffer
    p_rdy_s    = (state_r == S_STREAM) && !stall_in;
    w_hs_s     = bus.w_src_valid && w_rdy_s;
    p_hs_s     = bus.p_src_valid && p_rdy_s;
    w_last_s   = (w_cnt_r == W_CW'(W_TERM - 1));
    p_last_s   = (p_cnt_r == P_CW'(P_TERM - 1));
    oc_last_s  = (oc_idx == OC_W'(CHANNEL_NUM_OUT - 1));
    // results of pass n overlap the weight load of pass n+1, so count in all busy states
    r_active_s = (state_r == S_LOAD_W) || (state_r == S_STREAM) || (state_r == S_DRAIN);
    r_full_s   = (r_cnt_r == R_CW'(R_TERM));
    r_inc_s    = valid_result_in && r_active_s && !r_full_s;
    r_bad_s    = valid_result_in && !(r_active_s && !r_full_s);
    // include this cycle's result so done follows the last result by one cycle
    drain_done_s = r_full_s || (r_inc_s && (r_cnt_r == R_CW'(R_TERM - 1)));
  end

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_LOAD_W;
        else       state_s = S_IDLE;
      end
      S_LOAD_W: begin
        if (w_hs_s && w_last_s) state_s = S_STREAM;
        else                    state_s = S_LOAD_W;
      end
      S_STREAM: begin
        if (p_hs_s && p_last_s) state_s = oc_last_s ? S_DRAIN : S_LOAD_W;
        else                    state_s = S_STREAM;
      end
      S_DRAIN: begin
        if (drain_done_s) state_s = S_DONE;
        else              state_s = S_DRAIN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, counters, status flags and registered datapath outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= S_IDLE;
      w_cnt_r        <= '0;
      p_cnt_r        <= '0;
      r_cnt_r        <= '0;
      oc_idx         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      valid_weight_r <= 1'b0;
      valid_pxl_r    <= 1'b0;
      weight_r       <= '0;
      pxl_r          <= '0;
    end else begin
      state_r <= state_s;

      if (w_hs_s) w_cnt_r <= w_last_s ? '0 : w_cnt_r + W_CW'(1);
      if (p_hs_s) p_cnt_r <= p_last_s ? '0 : p_cnt_r + P_CW'(1);

      if (state_r == S_IDLE && start)             oc_idx <= '0;
      else if (p_hs_s && p_last_s && !oc_last_s)  oc_idx <= oc_idx + OC_W'(1);

      if (state_r == S_DONE) r_cnt_r <= '0;
      else if (r_inc_s)      r_cnt_r <= r_cnt_r + R_CW'(1);

      err  <= err | r_bad_s;
      busy <= (state_s == S_LOAD_W) || (state_s == S_STREAM) || (state_s == S_DRAIN);
      done <= (state_s == S_DONE);

      valid_weight_r <= w_hs_s;
      valid_pxl_r    <= p_hs_s;
      if (w_hs_s) weight_r <= bus.w_src_data;
      if (p_hs_s) pxl_r    <= bus.p_src_data;
    end
  end
endmodule

// File: tb/tb_conv_3x3_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_3x3_layer_sched
// Directed bench for the conv layer scheduler with K=3, CIN=2, COUT=2,
// IMAGE_SIZE=4 (18 weights and 8 pixels per pass, 8 results per layer).
// A transaction-level model (accepted-word totals per layer) predicts the
// readies, registered outputs and status every cycle; literal expectations
// pin word counts, data order, done timing and err behaviour.
// ---------------------------------------------------------------------------
module tb_conv_3x3_layer_sched;
  localparam int DW    = 32;
  localparam int K     = 3;
  localparam int CIN   = 2;
  localparam int COUT  = 2;
  localparam int IMG   = 4;
  localparam int WPP   = K * K * CIN;   // 18 weights per pass
  localparam int PPP   = IMG * CIN;     // 8 pixels per pass
  localparam int P_ALL = PPP * COUT;    // 16 pixels per layer
  localparam int R_ALL = IMG * COUT;    // 8 results per layer
  localparam logic [DW-1:0] W_BASE = 32'h0000_0100;

  logic       clk = 1'b0;
  logic       reset, start, stall_in, valid_result_in;
  logic       busy, done, err;
  logic [0:0] oc_idx;

  conv_3x3_layer_sched_if #(.DATA_WIDTH(DW)) bus ();

  conv_3x3_layer_sched #(
    .DATA_WIDTH(DW), .KERNEL(K), .CHANNEL_NUM_IN(CIN),
    .CHANNEL_NUM_OUT(COUT), .IMAGE_SIZE(IMG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall_in(stall_in),
    .bus(bus.master), .valid_result_in(valid_result_in),
    .busy(busy), .done(done), .oc_idx(oc_idx), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (layer totals) ----------------
  int m_run = 0, m_w = 0, m_p = 0, m_res = 0, m_oc = 0, m_done_now = 0, m_err = 0;
  int m_vw = 0, m_vp = 0;
  logic [DW-1:0] m_wd = '0, m_pd = '0;
  bit model_live = 1'b0;
  int cyc_cnt = 0;

  // weights of the current pass are wanted until WPP*(pass+1) have been taken
  function automatic bit exp_wr();
    return (m_run != 0) && (m_p < P_ALL) && (m_w < WPP * (m_p / PPP + 1));
  endfunction

  function automatic bit exp_pr();
    return (m_run != 0) && (m_p < P_ALL) && (m_w == WPP * (m_p / PPP + 1)) && !stall_in;
  endfunction

  // Model update on every rising edge from the bench-driven inputs
  always @(posedge clk) begin
    bit wr, pr, hw, hp;
    cyc_cnt++;
    if (!reset) begin
      m_run = 0; m_w = 0; m_p = 0; m_res = 0; m_oc = 0; m_done_now = 0; m_err = 0;
      m_vw = 0; m_vp = 0; m_wd = '0; m_pd = '0;
      model_live = 1'b1;
    end else begin
      wr = exp_wr();
      pr = exp_pr();
      hw = wr && bus.w_src_valid;
      hp = pr && bus.p_src_valid;
      m_vw = hw ? 1 : 0;
      m_vp = hp ? 1 : 0;
      if (hw) m_wd = bus.w_src_data;
      if (hp) m_pd = bus.p_src_data;
      if (valid_result_in) begin
        if (m_run != 0 && m_res < R_ALL) m_res++;
        else m_err = 1;
      end
      if (m_done_now != 0) begin
        m_done_now = 0;
        m_res = 0;
      end else if (m_run == 0) begin
        if (start) begin
          m_run = 1; m_w = 0; m_p = 0; m_oc = 0;
        end
      end else begin
        if (m_p == P_ALL && m_res == R_ALL) begin
          m_run = 0;
          m_done_now = 1;
        end
        if (hw) m_w++;
        if (hp) m_p++;
        m_oc = (m_p / PPP < COUT - 1) ? (m_p / PPP) : (COUT - 1);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_vw = 0, n_vp = 0, n_done = 0, done_cyc = 0, last_res_cyc = 0;

  // Compare DUT against the model mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      chk("w_src_ready", bus.w_src_ready, exp_wr());
      chk("p_src_ready", bus.p_src_ready, exp_pr());
      chk("valid_weight_out", bus.valid_weight_out, m_vw[0]);
      chk("weight_out", bus.weight_out, m_wd);
      chk("valid_pxl_out", bus.valid_pxl_out, m_vp[0]);
      chk("pxl_out", bus.pxl_out, m_pd);
      chk("busy", busy, m_run != 0);
      chk("done", done, m_done_now != 0);
      chk("oc_idx", oc_idx, m_oc[0]);
      chk("err", err, m_err[0]);
      if (bus.valid_weight_out) begin
        chk("weight_order", bus.weight_out, W_BASE + DW'(n_vw));
        n_vw++;
      end
      if (bus.valid_pxl_out) begin
        chk("pixel_order", bus.pxl_out, DW'(n_vp));
        n_vp++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc_cnt;
      end
      if (valid_result_in) last_res_cyc = cyc_cnt;
    end
  end

  // ---------------- stimulus ----------------
  int   w_seq = 0, p_seq = 0;
  bit   gappy = 1'b0;
  logic smp_pr;

  // advance one clock; sources present the next word after each acceptance
  task automatic step();
    logic wa, pa;
    @(negedge clk);
    wa = bus.w_src_valid & bus.w_src_ready;
    pa = bus.p_src_valid & bus.p_src_ready;
    smp_pr = bus.p_src_ready;
    @(posedge clk);
    #1;
    if (wa) w_seq++;
    if (pa) p_seq++;
    bus.w_src_data = W_BASE + DW'(w_seq);
    bus.p_src_data = DW'(p_seq);
    if (gappy) begin
      bus.w_src_valid = ~bus.w_src_valid;
      bus.p_src_valid = ~bus.p_src_valid;
    end
  endtask

  task automatic begin_layer(input bit gap);
    n_vw = 0; n_vp = 0; n_done = 0;
    w_seq = 0; p_seq = 0; gappy = gap;
    bus.w_src_data  = W_BASE;
    bus.p_src_data  = '0;
    bus.w_src_valid = 1'b1;
    bus.p_src_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_layer(input bit gap, input bit do_stall, input bit early, input bit start_mid);
    int res_left, early_left, stall_left, stall_seen, cyc;
    bit stalled, restarted, was_stall;
    begin_layer(gap);
    res_left = R_ALL; early_left = early ? 4 : 0;
    stall_left = 0; stall_seen = 0; cyc = 0; stalled = 0; restarted = 0;
    while (n_done == 0 && cyc < 400) begin
      valid_result_in = 1'b0;
      start = 1'b0;
      if (do_stall && !stalled && p_seq == PPP / 2) begin
        stall_left = 3;
        stalled = 1'b1;
      end
      stall_in = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      if (start_mid && !restarted && p_seq == 3) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (early_left > 0 && w_seq > WPP && w_seq < 2 * WPP) begin
        valid_result_in = 1'b1;
        early_left--;
        res_left--;
      end else if (p_seq == P_ALL && res_left > 0) begin
        valid_result_in = 1'b1;
        res_left--;
      end
      was_stall = stall_in;
      step();
      cyc++;
      if (was_stall) begin
        chk("stall_blocks_ready", smp_pr, 1'b0);
        stall_seen++;
      end
    end
    valid_result_in = 1'b0;
    stall_in = 1'b0;
    start = 1'b0;
    chk("done_within_budget", n_done != 0, 1'b1);
    step();
    step();
    chk("weights_per_layer", n_vw, 36);
    chk("pixels_per_layer", n_vp, 16);
    chk("done_pulses", n_done, 1);
    chk("done_after_last_result", done_cyc - last_res_cyc, 1);
    chk("busy_after_done", busy, 1'b0);
    chk("err_clean_layer", err, 1'b0);
    if (do_stall) chk("stall_cycles", stall_seen, 3);
  endtask

  initial begin
    int cyc;
    reset = 1'b0; start = 1'b0; stall_in = 1'b0; valid_result_in = 1'b0;
    bus.w_src_valid = 1'b0; bus.p_src_valid = 1'b0;
    bus.w_src_data = '0; bus.p_src_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_oc_idx", oc_idx, 1'b0);
    chk("reset_w_ready", bus.w_src_ready, 1'b0);
    chk("reset_vpxl", bus.valid_pxl_out, 1'b0);
    reset = 1'b1;
    step();

    // plain layer, then stall mid-stream, then gappy sources
    run_layer(1'b0, 1'b0, 1'b0, 1'b0);
    run_layer(1'b0, 1'b1, 1'b0, 1'b0);
    run_layer(1'b1, 1'b0, 1'b0, 1'b0);
    gappy = 1'b0;

    // half the results during the pass-1 weight load, then one surplus result
    run_layer(1'b0, 1'b0, 1'b1, 1'b0);
    valid_result_in = 1'b1;
    step();
    valid_result_in = 1'b0;
    step();
    chk("err_on_surplus", err, 1'b1);
    repeat (3) step();
    chk("err_sticky", err, 1'b1);

    // abort with reset in the middle of pass 1 streaming
    begin_layer(1'b0);
    cyc = 0;
    while (p_seq < PPP + 2 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("reached_pass1_stream", oc_idx, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_err", err, 1'b0);
    chk("abort_oc_idx", oc_idx, 1'b0);
    chk("abort_vw", bus.valid_weight_out, 1'b0);
    chk("abort_vp", bus.valid_pxl_out, 1'b0);
    chk("abort_wdata", bus.weight_out, '0);
    chk("abort_pdata", bus.pxl_out, '0);
    chk("abort_p_ready", bus.p_src_ready, 1'b0);
    step();

    // fresh layer with a stray start during streaming
    run_layer(1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
